// File: rtl/sound_ram_arbiter.sv
// Single-port 64 KB sound RAM arbiter: DOC sample fetches have priority over queued GLU host accesses.
// Define SOUND_RAM_CLEAR_EN to zero-fill the whole RAM after reset before any request is served.
module sound_ram_arbiter #(
  parameter int HOST_FIFO_DEPTH = 2,
  parameter int MAX_DOC_STREAK  = 4,
  parameter int ADDR_W          = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_doc_req,
  input  logic [ADDR_W-1:0] i_doc_addr,
  output logic              o_doc_gnt,
  output logic              o_doc_rvalid,
  output logic [7:0]        o_doc_rdata,
  input  logic              i_host_wr,
  input  logic              i_host_rd,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [7:0]        i_host_wdata,
  output logic              o_host_busy,
  output logic              o_host_rvalid,
  output logic [7:0]        o_host_rdata,
  output logic              o_host_ovf,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [7:0]        o_ram_din,
  output logic              o_ram_we,
  input  logic [7:0]        i_ram_dout
);

  localparam int PTR_W = $clog2(HOST_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STK_W = $clog2(MAX_DOC_STREAK + 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [STK_W-1:0]   r_streak;
  logic               r_tag0_vld;
  logic               r_tag0_host;
  logic               r_tag1_vld;
  logic               r_tag1_host;
`ifdef SOUND_RAM_CLEAR_EN
  logic [ADDR_W-1:0]  r_clr_addr;
`endif

  logic               r_fifo_we    [HOST_FIFO_DEPTH];
  logic [ADDR_W-1:0]  r_fifo_addr  [HOST_FIFO_DEPTH];
  logic [7:0]         r_fifo_wdata [HOST_FIFO_DEPTH];

  logic w_run;
  logic w_fifo_empty;
  logic w_fifo_full;
  logic w_doc_win;
  logic w_host_win;
  logic w_push_any;
  logic w_push_ok;
  logic w_ovf_evt;

  assign w_run        = (r_state == ST_RUN);
  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == CNT_W'(HOST_FIFO_DEPTH));
  assign w_doc_win    = w_run & i_doc_req &
                        (w_fifo_empty | (r_streak < STK_W'(MAX_DOC_STREAK)));
  assign w_host_win   = w_run & ~w_doc_win & ~w_fifo_empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_push_any   = i_host_wr | i_host_rd;
  assign w_push_ok    = w_push_any & w_run & (~w_fifo_full | w_host_win);
  assign w_ovf_evt    = (i_host_wr & i_host_rd) | (w_push_any & ~w_push_ok);
  assign o_host_busy  = w_fifo_full | ~w_run;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_fifo_we[r_wr_ptr]    <= i_host_wr;
      r_fifo_addr[r_wr_ptr]  <= i_host_addr;
      r_fifo_wdata[r_wr_ptr] <= i_host_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
`ifdef SOUND_RAM_CLEAR_EN
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
`else
      r_state    <= ST_RUN;
`endif
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_streak      <= '0;
      r_tag0_vld    <= 1'b0;
      r_tag0_host   <= 1'b0;
      r_tag1_vld    <= 1'b0;
      r_tag1_host   <= 1'b0;
      o_doc_gnt     <= 1'b0;
      o_doc_rvalid  <= 1'b0;
      o_doc_rdata   <= '0;
      o_host_rvalid <= 1'b0;
      o_host_rdata  <= '0;
      o_host_ovf    <= 1'b0;
      o_ram_addr    <= '0;
      o_ram_din     <= '0;
      o_ram_we      <= 1'b0;
    end else begin
      o_doc_gnt   <= 1'b0;
      o_ram_we    <= 1'b0;
      r_tag0_vld  <= 1'b0;
      r_tag0_host <= 1'b0;
      // Tag stage 1 lines up with ram_dout, which lags the issued address by one cycle.
      r_tag1_vld    <= r_tag0_vld;
      r_tag1_host   <= r_tag0_host;
      o_doc_rvalid  <= r_tag1_vld & ~r_tag1_host;
      o_host_rvalid <= r_tag1_vld & r_tag1_host;
      if (r_tag1_vld & ~r_tag1_host) o_doc_rdata  <= i_ram_dout;
      if (r_tag1_vld & r_tag1_host)  o_host_rdata <= i_ram_dout;

`ifdef SOUND_RAM_CLEAR_EN
      if (r_state == ST_CLEAR) begin
        o_ram_we   <= 1'b1;
        o_ram_addr <= r_clr_addr;
        o_ram_din  <= 8'h00;
        r_clr_addr <= r_clr_addr + 1'b1;
        if (r_clr_addr == '1) r_state <= ST_RUN;
      end else
`endif
      begin
        if (w_doc_win) begin
          o_doc_gnt  <= 1'b1;
          o_ram_addr <= i_doc_addr;
          r_tag0_vld <= 1'b1;
        end else if (w_host_win) begin
          o_ram_addr  <= r_fifo_addr[r_rd_ptr];
          o_ram_din   <= r_fifo_wdata[r_rd_ptr];
          o_ram_we    <= r_fifo_we[r_rd_ptr];
          r_tag0_vld  <= ~r_fifo_we[r_rd_ptr];
          r_tag0_host <= 1'b1;
        end
      end

      if (w_push_ok)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_host_win) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_host_win);

      if (w_host_win | w_fifo_empty)
        r_streak <= '0;
      else if (w_doc_win && r_streak < STK_W'(MAX_DOC_STREAK))
        r_streak <= r_streak + 1'b1;

      if (w_ovf_evt) o_host_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sound_ram_arbiter.sv
// Bench for sound_ram_arbiter: directed scenarios plus random traffic against a queue-based model.
// The RAM is a registered-read array inside the bench; the model keeps its own memory image.
module tb_sound_ram_arbiter;

  localparam int DEPTH = 2;
  localparam int MAXS  = 4;
`ifdef SOUND_RAM_CLEAR_EN
  localparam logic CLR_BUILD = 1'b1;
`else
  localparam logic CLR_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        doc_req = 1'b0;
  logic [15:0] doc_addr = '0;
  logic        host_wr = 1'b0;
  logic        host_rd = 1'b0;
  logic [15:0] host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic [7:0]  ram_dout = '0;

  logic        o_doc_gnt, o_doc_rvalid, o_host_busy, o_host_rvalid, o_host_ovf, o_ram_we;
  logic [7:0]  o_doc_rdata, o_host_rdata, o_ram_din;
  logic [15:0] o_ram_addr;

  int checks = 0;
  int failures = 0;

  sound_ram_arbiter #(.HOST_FIFO_DEPTH(DEPTH), .MAX_DOC_STREAK(MAXS), .ADDR_W(16)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_doc_req(doc_req), .i_doc_addr(doc_addr),
    .o_doc_gnt(o_doc_gnt), .o_doc_rvalid(o_doc_rvalid), .o_doc_rdata(o_doc_rdata),
    .i_host_wr(host_wr), .i_host_rd(host_rd), .i_host_addr(host_addr), .i_host_wdata(host_wdata),
    .o_host_busy(o_host_busy), .o_host_rvalid(o_host_rvalid), .o_host_rdata(o_host_rdata),
    .o_host_ovf(o_host_ovf),
    .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din), .o_ram_we(o_ram_we), .i_ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  logic [7:0] ram_mem [65536];
  always @(posedge clk) begin
    ram_dout <= ram_mem[o_ram_addr];
    if (o_ram_we) ram_mem[o_ram_addr] <= o_ram_din;
  end

  // Reference model: host queue, return list with due cycle, flat memory image.
  typedef struct { bit we; bit [15:0] addr; bit [7:0] data; } hreq_t;
  typedef struct { int due; bit host; bit [7:0] data; } ret_t;

  hreq_t      m_q[$];
  ret_t       m_ret[$];
  logic [7:0] m_mem [65536];
  int         m_streak = 0;
  int         m_cyc = 0;
  bit         m_ovf = 0, m_doc_gnt = 0, m_we = 0, m_doc_rv = 0, m_host_rv = 0;
  bit [15:0]  m_addr = '0;
  bit [7:0]   m_din = '0, m_doc_rdat = '0, m_host_rdat = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ret.delete();
    m_streak = 0; m_ovf = 0; m_doc_gnt = 0; m_we = 0; m_doc_rv = 0; m_host_rv = 0;
    m_addr = '0; m_din = '0; m_doc_rdat = '0; m_host_rdat = '0;
  endtask

  task automatic model_edge();
    bit doc_win, host_win;
    int n0;
    hreq_t h;
    ret_t r;
    m_cyc++;
    n0 = m_q.size();
    doc_win  = doc_req && (n0 == 0 || m_streak < MAXS);
    host_win = !doc_win && n0 > 0;
    m_doc_gnt = doc_win;
    m_we = 0;
    if (doc_win) begin
      m_addr = doc_addr;
      r.due = m_cyc + 2; r.host = 0; r.data = m_mem[doc_addr];
      m_ret.push_back(r);
    end else if (host_win) begin
      h = m_q.pop_front();
      m_addr = h.addr;
      if (h.we) begin
        m_we = 1; m_din = h.data; m_mem[h.addr] = h.data;
      end else begin
        r.due = m_cyc + 2; r.host = 1; r.data = m_mem[h.addr];
        m_ret.push_back(r);
      end
    end
    if (host_win || n0 == 0) m_streak = 0;
    else if (doc_win && m_streak < MAXS) m_streak++;
    if (host_wr || host_rd) begin
      if (host_wr && host_rd) m_ovf = 1;
      if (m_q.size() < DEPTH) begin
        h.we = host_wr; h.addr = host_addr; h.data = host_wdata;
        m_q.push_back(h);
      end else m_ovf = 1;
    end
    m_doc_rv = 0; m_host_rv = 0;
    if (m_ret.size() > 0 && m_ret[0].due == m_cyc) begin
      r = m_ret.pop_front();
      if (r.host) begin m_host_rv = 1; m_host_rdat = r.data; end
      else begin m_doc_rv = 1; m_doc_rdat = r.data; end
    end
  endtask

  task automatic compare();
    chk("doc_gnt", o_doc_gnt, m_doc_gnt);
    chk("ram_we", o_ram_we, m_we);
    chk("ram_addr", o_ram_addr, m_addr);
    if (m_we) chk("ram_din", o_ram_din, m_din);
    chk("doc_rvalid", o_doc_rvalid, m_doc_rv);
    chk("host_rvalid", o_host_rvalid, m_host_rv);
    chk("doc_rdata", o_doc_rdata, m_doc_rdat);
    chk("host_rdata", o_host_rdata, m_host_rdat);
    chk("host_busy", o_host_busy, m_q.size() == DEPTH);
    chk("host_ovf", o_host_ovf, m_ovf);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic push(input bit wr, input bit [15:0] a, input bit [7:0] d);
    host_wr = wr; host_rd = !wr; host_addr = a; host_wdata = d;
    tick();
    host_wr = 0; host_rd = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"}, o_doc_gnt, 0);
    chk({tag, "_drv"}, o_doc_rvalid, 0);
    chk({tag, "_hrv"}, o_host_rvalid, 0);
    chk({tag, "_we"}, o_ram_we, 0);
    chk({tag, "_addr"}, o_ram_addr, 0);
    chk({tag, "_ovf"}, o_host_ovf, 0);
    chk({tag, "_busy"}, o_host_busy, CLR_BUILD);
    chk({tag, "_drd"}, o_doc_rdata, 0);
    chk({tag, "_hrd"}, o_host_rdata, 0);
  endtask

`ifdef SOUND_RAM_CLEAR_EN
  task automatic wait_clear();
    int n = 0;
    for (int i = 0; i < 70000 && o_host_busy; i++) begin
      @(posedge clk); #1;
      if (o_ram_we && o_ram_din == 8'h00) n++;
    end
    chk("clr_writes", n, 65536);
    m_addr = 16'hFFFF;
  endtask
`endif

  initial begin
    int n, seen, dv, hv, r;
    for (int i = 0; i < 65536; i++) begin ram_mem[i] = '0; m_mem[i] = '0; end
    #1 rst = 1'b1;
    #2 check_reset_outputs("rst0");
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
`ifdef SOUND_RAM_CLEAR_EN
    wait_clear();
    push(0, 16'hFFFF, 8'h00);
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (o_host_rvalid) begin seen = 1; chk("clr_rd_ffff", o_host_rdata, 8'h00); end
    end
    chk("clr_rd_seen", seen, 1);
`endif

    // write then read same address
    push(1, 16'h1234, 8'hA5);
    push(0, 16'h1234, 8'h00);
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (o_host_rvalid) begin seen = 1; chk("s1_rdata", o_host_rdata, 8'hA5); end
    end
    chk("s1_seen", seen, 1);
    repeat (2) tick();

    // DOC streak limit with one queued write
    doc_req = 1; doc_addr = 16'h0100;
    push(1, 16'h2000, 8'h5A);
    n = 0; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (o_ram_we) seen = 1;
      else if (o_doc_gnt) n++;
    end
    chk("s2_wr_seen", seen, 1);
    chk("s2_doc_grants", n, 4);
    tick();
    chk("s2_doc_resume", o_doc_gnt, 1);
    doc_req = 0;
    repeat (3) tick();

    // DOC read then host read on consecutive cycles
    push(1, 16'h0040, 8'h3C);
    push(1, 16'h0041, 8'hC3);
    repeat (3) tick();
    doc_req = 1; doc_addr = 16'h0040;
    host_rd = 1; host_addr = 16'h0041;
    tick();
    doc_req = 0; host_rd = 0;
    dv = 0; hv = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (o_doc_rvalid) begin dv = i; chk("s4_doc_data", o_doc_rdata, 8'h3C); end
      if (o_host_rvalid) begin hv = i; chk("s4_host_data", o_host_rdata, 8'hC3); end
    end
    chk("s4_doc_lat", dv, 2);
    chk("s4_host_lat", hv, 3);

    // three pushes into a depth-2 FIFO while DOC hogs the RAM
    doc_req = 1; doc_addr = 16'h0200;
    push(1, 16'h0030, 8'h01);
    push(1, 16'h0031, 8'h02);
    chk("s3_busy", o_host_busy, 1);
    chk("s3_ovf_before", o_host_ovf, 0);
    push(1, 16'h0032, 8'h03);
    chk("s3_ovf", o_host_ovf, 1);
    doc_req = 0;
    repeat (5) tick();

`ifndef SOUND_RAM_CLEAR_EN
    // reset one cycle after a DOC grant
    doc_req = 1; doc_addr = 16'h0040;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (o_doc_gnt) seen = 1;
    end
    chk("s5_gnt_seen", seen, 1);
    doc_req = 0;
    tick();
    rst = 1'b1;
    #1 check_reset_outputs("s5");
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    dv = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_doc_rvalid || o_host_rvalid) dv++;
    end
    chk("s5_no_rvalid", dv, 0);
`endif

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (!doc_req || m_doc_gnt) begin
        doc_req = ($urandom_range(0, 99) < 55);
        doc_addr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {12'h000, 4'($urandom)};
      end
      host_wr = 0; host_rd = 0;
      r = $urandom_range(0, 99);
      if (r < 20) host_wr = 1;
      else if (r < 40) host_rd = 1;
      else if (r < 42) begin host_wr = 1; host_rd = 1; end
      host_addr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {12'h000, 4'($urandom)};
      host_wdata = 8'($urandom);
      tick();
    end
    doc_req = 0; host_wr = 0; host_rd = 0;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
